pong_ball_ctrl: RTL and testbench

Per-frame ball motion controller for the Pong VGA demo. Once per frame, on the `screenbegin` pulse, it advances the ball by a programmable speed. It bounces the ball off the top and bottom walls and off two paddles, and detects goals. It then writes the new X and Y location to a ball sprite instance over that sprite's `data_in` / `x_N_loc_en` / `y_N_loc_en` load port, so the sprite picks the position up at the following frame start.

---
 rtl/pong_ball_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl
// Per-frame ball motion controller for the Pong VGA demo. On each accepted
// frame-start pulse it advances the ball by `speed` pixels per axis. It
// bounces off the walls and paddles and detects goals. It then loads the new
// X and Y location into the ball sprite over its data_in / loc_en load port.
//
// Ports:
//   px_clk       pixel clock
//   rst          asynchronous active-high reset
//   screenbegin  one-cycle frame-start pulse
//   run          motion enable level (only gates the start from IDLE)
//   serve        one-cycle pulse releasing the ball after a goal
//   speed        pixels moved per frame on each axis
//   lpad_y       left paddle top edge
//   rpad_y       right paddle top edge
//   data_out     sprite data_in (X during the X write, Y during the Y write)
//   x_N_loc_en   sprite X load strobe
//   y_N_loc_en   sprite Y load strobe
//   score_l      left player scored (pulse, coincides with the X write)
//   score_r      right player scored (pulse, coincides with the X write)
//   busy         high while a calc/write sequence is in flight
module pong_ball_ctrl #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned V_ACTIVE  = 1024,
  parameter int unsigned BALL_SIZE = 20,
  parameter int unsigned PADDLE_W  = 20,
  parameter int unsigned PADDLE_H  = 100,
  parameter int unsigned LPAD_X    = 40,
  parameter int unsigned RPAD_X    = 1220,
  parameter int unsigned INIT_X    = 630,
  parameter int unsigned INIT_Y    = 502
) (
  input  logic        px_clk,
  input  logic        rst,
  input  logic        screenbegin,
  input  logic        run,
  input  logic        serve,
  input  logic [3:0]  speed,
  input  logic [15:0] lpad_y,
  input  logic [15:0] rpad_y,
  output logic [15:0] data_out,
  output logic        x_N_loc_en,
  output logic        y_N_loc_en,
  output logic        score_l,
  output logic        score_r,
  output logic        busy
);

  localparam logic [16:0] BS17      = 17'(BALL_SIZE);
  localparam logic [16:0] PH17      = 17'(PADDLE_H);
  localparam logic [16:0] LEDGE17   = 17'(LPAD_X + PADDLE_W);
  localparam logic [16:0] RPAD17    = 17'(RPAD_X);
  localparam logic [16:0] YMAX17    = 17'(V_ACTIVE - BALL_SIZE);
  localparam logic [16:0] XMAX17    = 17'(H_ACTIVE - BALL_SIZE);
  localparam logic [15:0] INIT_X16  = 16'(INIT_X);
  localparam logic [15:0] INIT_Y16  = 16'(INIT_Y);
  localparam logic [15:0] LBOUNCE16 = 16'(LPAD_X + PADDLE_W);
  localparam logic [15:0] RBOUNCE16 = 16'(RPAD_X - BALL_SIZE);
  localparam logic [15:0] YMAX16    = 16'(V_ACTIVE - BALL_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WRITE_X,
    S_WRITE_Y,
    S_WAIT_SERVE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bx_q, bx_d, by_q, by_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic        goal_q, goal_d;
  logic [15:0] data_out_q, data_out_d;
  logic        x_en_q, x_en_d, y_en_q, y_en_d;
  logic        score_l_q, score_l_d, score_r_q, score_r_d;
  logic        busy_q, busy_d;

  // Candidate motion and collision terms, all 17-bit so sums never wrap.
  logic [16:0] spd17, bx17, by17, nx, ny;
  logic        ovl_l, ovl_r, hit_l, hit_r, goal_left, goal_right;

  always_comb begin
    spd17 = {13'd0, speed};
    bx17  = {1'b0, bx_q};
    by17  = {1'b0, by_q};
    nx    = dx_q ? bx17 + spd17 : bx17 - spd17;
    ny    = dy_q ? by17 + spd17 : by17 - spd17;
    // Paddle overlap uses the pre-move Y position.
    ovl_l = (by17 + BS17 > {1'b0, lpad_y}) && (by17 < {1'b0, lpad_y} + PH17);
    ovl_r = (by17 + BS17 > {1'b0, rpad_y}) && (by17 < {1'b0, rpad_y} + PH17);
    hit_l = !dx_q && (bx17 >= LEDGE17) && (nx <= LEDGE17) && ovl_l;
    hit_r = dx_q && (bx17 + BS17 <= RPAD17) && (nx + BS17 >= RPAD17) && ovl_r;
    goal_left  = !dx_q && !hit_l && (bx17 < spd17);
    goal_right = dx_q && !hit_r && (nx > XMAX17);
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    goal_d  = goal_q;

    unique case (state_q)
      S_IDLE: begin
        if (screenbegin && run) state_d = S_CALC;
      end
      S_CALC: begin
        if (!dy_q && (by17 < spd17)) begin
          by_d = '0;
          dy_d = 1'b1;
        end else if (dy_q && (ny > YMAX17)) begin
          by_d = YMAX16;
          dy_d = 1'b0;
        end else begin
          by_d = ny[15:0];
        end

        if (hit_l) begin
          bx_d = LBOUNCE16;
          dx_d = 1'b1;
        end else if (hit_r) begin
          bx_d = RBOUNCE16;
          dx_d = 1'b0;
        end else if (goal_left || goal_right) begin
          // A goal re-serves from the centre and overrides any wall bounce;
          // dx remembers which side scored for the score pulse.
          bx_d   = INIT_X16;
          by_d   = INIT_Y16;
          dy_d   = 1'b1;
          dx_d   = goal_right;
          goal_d = 1'b1;
        end else begin
          bx_d = nx[15:0];
        end
        state_d = S_WRITE_X;
      end
      S_WRITE_X: state_d = S_WRITE_Y;
      S_WRITE_Y: state_d = goal_q ? S_WAIT_SERVE : S_IDLE;
      S_WAIT_SERVE: begin
        if (serve) begin
          goal_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the current state, so each strobe
  // appears one cycle after its state is entered.
  always_comb begin
    data_out_d = '0;
    x_en_d     = 1'b0;
    y_en_d     = 1'b0;
    score_l_d  = 1'b0;
    score_r_d  = 1'b0;
    busy_d     = (state_q != S_IDLE) && (state_q != S_WAIT_SERVE);
    if (state_q == S_WRITE_X) begin
      data_out_d = bx_q;
      x_en_d     = 1'b1;
      score_l_d  = goal_q && dx_q;
      score_r_d  = goal_q && !dx_q;
    end else if (state_q == S_WRITE_Y) begin
      data_out_d = by_q;
      y_en_d     = 1'b1;
    end
  end

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WRITE_X;
      bx_q       <= INIT_X16;
      by_q       <= INIT_Y16;
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      goal_q     <= 1'b0;
      data_out_q <= '0;
      x_en_q     <= 1'b0;
      y_en_q     <= 1'b0;
      score_l_q  <= 1'b0;
      score_r_q  <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      goal_q     <= goal_d;
      data_out_q <= data_out_d;
      x_en_q     <= x_en_d;
      y_en_q     <= y_en_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign x_N_loc_en = x_en_q;
  assign y_N_loc_en = y_en_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Testbench for pong_ball_ctrl: a behavioural ball model pushes the expected
// sprite writes into a scoreboard queue as each frame is started; a monitor
// pops and compares them when the DUT issues its load strobes.
module tb_pong_ball_ctrl;

  logic        px_clk = 1'b0;
  logic        rst = 1'b1;
  logic        screenbegin = 1'b0;
  logic        run = 1'b1;
  logic        serve = 1'b0;
  logic [3:0]  speed = '0;
  logic [15:0] lpad_y = '0;
  logic [15:0] rpad_y = '0;
  logic [15:0] data_out;
  logic        x_N_loc_en, y_N_loc_en, score_l, score_r, busy;

  pong_ball_ctrl dut (
    .px_clk      (px_clk),
    .rst         (rst),
    .screenbegin (screenbegin),
    .run         (run),
    .serve       (serve),
    .speed       (speed),
    .lpad_y      (lpad_y),
    .rpad_y      (rpad_y),
    .data_out    (data_out),
    .x_N_loc_en  (x_N_loc_en),
    .y_N_loc_en  (y_N_loc_en),
    .score_l     (score_l),
    .score_r     (score_r),
    .busy        (busy)
  );

  always #5 px_clk = ~px_clk;

  typedef struct {
    int x;
    int y;
    int sl;
    int sr;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  exp_l = 0, exp_r = 0, cnt_l = 0, cnt_r = 0;

  // Behavioural ball model
  int m_bx = 630, m_by = 502, m_dx = 1, m_dy = 1;
  bit m_goal = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bx = 630; m_by = 502; m_dx = 1; m_dy = 1; m_goal = 1'b0;
  endtask

  task automatic model_step(input int s, input int lp, input int rp, output sb_t e);
    int nx, ny, nbx, nby, ndx, ndy;
    bit ovl_l, ovl_r, lb, rb, gl, gr;
    nx = (m_dx != 0) ? m_bx + s : m_bx - s;
    ny = (m_dy != 0) ? m_by + s : m_by - s;
    if (m_dy == 0 && m_by < s) begin
      nby = 0; ndy = 1;
    end else if (m_dy == 1 && ny > 1004) begin
      nby = 1004; ndy = 0;
    end else begin
      nby = ny; ndy = m_dy;
    end
    ovl_l = (m_by + 20 > lp) && (m_by < lp + 100);
    ovl_r = (m_by + 20 > rp) && (m_by < rp + 100);
    lb = (m_dx == 0) && (m_bx >= 60) && (nx <= 60) && ovl_l;
    rb = (m_dx == 1) && (m_bx + 20 <= 1220) && (nx + 20 >= 1220) && ovl_r;
    gl = !lb && (m_dx == 0) && (m_bx < s);
    gr = !rb && (m_dx == 1) && (nx > 1260);
    ndx = m_dx;
    nbx = nx;
    if (lb) begin
      nbx = 60; ndx = 1;
    end else if (rb) begin
      nbx = 1200; ndx = 0;
    end else if (gl || gr) begin
      nbx = 630; nby = 502; ndy = 1; ndx = gl ? 0 : 1;
    end
    e.x = nbx; e.y = nby; e.sl = gr ? 1 : 0; e.sr = gl ? 1 : 0;
    if (gr) exp_l++;
    if (gl) exp_r++;
    m_goal = gl || gr;
    m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
  endtask

  function automatic int away(input int y);
    return (y < 500) ? 800 : 0;
  endfunction

  function automatic int track(input int y);
    return (y >= 40) ? y - 40 : 0;
  endfunction

  // Scoreboard monitor
  sb_t cur = '{x: 0, y: 0, sl: 0, sr: 0};
  bit  prev_x = 1'b0;
  always @(negedge px_clk) begin
    if (!rst) begin
      check("strobe_excl", x_N_loc_en & y_N_loc_en, 0);
      if (x_N_loc_en) begin
        if (sb_q.size() == 0) check("x_unexpected", x_N_loc_en, 0);
        else begin
          cur = sb_q.pop_front();
          check("x_data", data_out, cur.x);
          check("x_score_l", score_l, cur.sl);
          check("x_score_r", score_r, cur.sr);
        end
      end else begin
        check("score_quiet", {score_l, score_r}, 0);
      end
      if (y_N_loc_en) begin
        check("y_after_x", prev_x, 1);
        check("y_data", data_out, cur.y);
      end
      if (!x_N_loc_en && !y_N_loc_en) check("data_idle", data_out, 0);
      if (score_l) cnt_l++;
      if (score_r) cnt_r++;
      prev_x = x_N_loc_en;
    end else begin
      prev_x = 1'b0;
    end
  end

  // One frame: the pulse is sampled at edge T; strobes after T+2 and T+3.
  task automatic frame(input int s, input int lp, input int rp,
                       input bit extra_sb, input bit drop_run, input bit rst_after_y);
    sb_t e;
    speed  = 4'(s);
    lpad_y = 16'(lp);
    rpad_y = 16'(rp);
    model_step(s, lp, rp, e);
    sb_q.push_back(e);
    @(negedge px_clk) screenbegin = 1'b1;
    @(negedge px_clk);                 // after T: in CALC
    screenbegin = extra_sb;
    if (drop_run) run = 1'b0;
    check("busy_calc", busy, 0);
    @(negedge px_clk);                 // after T+1
    screenbegin = 1'b0;
    check("x_not_early", x_N_loc_en, 0);
    @(negedge px_clk);                 // after T+2
    check("x_latency", x_N_loc_en, 1);
    check("busy_write", busy, 1);
    @(negedge px_clk);                 // after T+3
    check("y_latency", y_N_loc_en, 1);
    if (rst_after_y) begin
      #2 rst = 1'b1;
      #1;
      check("rst_y_drop", y_N_loc_en, 0);
      check("rst_data", data_out, 0);
      model_reset();
      sb_q.push_back('{x: 630, y: 502, sl: 0, sr: 0});
      @(negedge px_clk) rst = 1'b0;
      @(negedge px_clk) check("rst2_x", x_N_loc_en, 1);
      @(negedge px_clk) check("rst2_y", y_N_loc_en, 1);
    end
    @(negedge px_clk);                 // after T+4
    check("busy_done", busy, 0);
    run = 1'b1;
  endtask

  task automatic wait_serve();
    repeat (3) begin
      @(negedge px_clk) screenbegin = 1'b1;
      @(negedge px_clk) screenbegin = 1'b0;
    end
    repeat (4) @(negedge px_clk);
    check("wait_serve_busy", busy, 0);
    @(negedge px_clk) serve = 1'b1;
    @(negedge px_clk) serve = 1'b0;
    m_goal = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and the post-reset write of the serve position
    repeat (2) @(negedge px_clk);
    check("rst_xen", x_N_loc_en, 0);
    check("rst_yen", y_N_loc_en, 0);
    check("rst_scores", {score_l, score_r}, 0);
    check("rst_data0", data_out, 0);
    sb_q.push_back('{x: 630, y: 502, sl: 0, sr: 0});
    @(negedge px_clk) rst = 1'b0;
    @(negedge px_clk) check("rst_x", x_N_loc_en, 1);
    @(negedge px_clk) check("rst_y", y_N_loc_en, 1);
    @(negedge px_clk) check("rst_idle_busy", busy, 0);

    // Free motion: 630,502 -> 634,506
    frame(4, away(m_by), away(m_by), 0, 0, 0);

    // run low: screenbegin must not start a sequence
    run = 1'b0;
    @(negedge px_clk) screenbegin = 1'b1;
    @(negedge px_clk) screenbegin = 1'b0;
    repeat (5) @(negedge px_clk);
    check("run_low_busy", busy, 0);
    run = 1'b1;

    // Rally with both paddles tracking: walls and paddle bounces, speed 0 included
    for (int i = 0; i < 60; i++)
      frame($urandom_range(0, 15), track(m_by), track(m_by), 0, 0, 0);

    // Left paddle misses: rally until a left goal
    for (int i = 0; i < 300 && !m_goal; i++)
      frame($urandom_range(10, 15), away(m_by), track(m_by), 0, 0, 0);
    if (m_goal) wait_serve();

    // Right paddle misses: rally until a right goal
    for (int i = 0; i < 300 && !m_goal; i++)
      frame($urandom_range(10, 15), track(m_by), away(m_by), 0, 0, 0);
    if (m_goal) wait_serve();

    // run dropped mid-sequence still completes the writes
    frame(7, away(m_by), away(m_by), 0, 1, 0);

    // Extra screenbegin during CALC is dropped; reset during the Y write
    frame(3, away(m_by), away(m_by), 1, 0, 1);
    frame(5, away(m_by), away(m_by), 0, 0, 0);

    repeat (4) @(negedge px_clk);
    check("sb_drained", sb_q.size(), 0);
    check("score_l_count", cnt_l, exp_l);
    check("score_r_count", cnt_r, exp_r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
